// File: rtl/packet_receiver_pkg.sv
// Shared constants and types for the serial packet receiver.
// Holds the control-packet codes, default framing parameters and FSM state encoding.
// Imported by packet_receiver; contains no logic.
package packet_receiver_pkg;

    // Default framing: payload bits after the start bit, and idle-low bits between packets
    localparam int DEF_PKT_BITS = 40;
    localparam int DEF_GAP_BITS = 3;

    // Control packets recognised by exact compare; everything else is data
    localparam logic [39:0] AUDIO_REQ_PKT      = 40'h0700000000;
    localparam logic [39:0] AUDIO_UNDERRUN_PKT = 40'h0f00000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/packet_receiver.sv
// Serial packet receiver: start bit + PKT_BITS payload (MSB first), then a GAP_BITS idle-low gap.
// Latency: classification/outputs register 1 cycle after the last payload bit is sampled.
// Backpressure: out_valid/out_ready hold one data packet; a new data packet while held and not consumed is dropped (data_loss).
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   sin                   serial line, idles low, sampled on rising edge
//   out_data/out_valid    last received data packet and its valid flag
//   out_ready             consumer accept (handshake on out_valid && out_ready)
//   audio_req             1-cycle pulse on audio-request control packet
//   audio_underrun        1-cycle pulse on audio-underrun control packet
//   data_loss             1-cycle pulse when a data packet is dropped
//   framing_error         1-cycle pulse when sin is high during the gap
module packet_receiver
    import packet_receiver_pkg::*;
#(
    parameter int PKT_BITS = DEF_PKT_BITS,
    parameter int GAP_BITS = DEF_GAP_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sin,
    output logic [PKT_BITS-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                audio_req,
    output logic                audio_underrun,
    output logic                data_loss,
    output logic                framing_error
);

    localparam logic [6:0]          BIT_LAST  = 7'(PKT_BITS - 1);
    localparam logic [6:0]          GAP_LAST  = 7'(GAP_BITS - 1);
    localparam logic [PKT_BITS-1:0] AREQ_CODE = PKT_BITS'(AUDIO_REQ_PKT);
    localparam logic [PKT_BITS-1:0] AUND_CODE = PKT_BITS'(AUDIO_UNDERRUN_PKT);

    state_t              r_state;
    logic [6:0]          r_bit_cnt;
    logic [6:0]          r_gap_cnt;
    logic [PKT_BITS-1:0] r_shift;
    logic                r_pkt_done;    // r_shift holds a complete packet this cycle
    logic                r_frm_pend;    // sin was high during the gap last edge
    logic [PKT_BITS-1:0] r_out_data;
    logic                r_out_valid;
    logic                r_audio_req;
    logic                r_audio_underrun;
    logic                r_data_loss;
    logic                r_framing_error;

    logic w_is_areq;
    logic w_is_aund;
    logic w_is_data;
    logic w_consume;
    logic w_load;
    logic w_drop;

    assign w_is_areq = (r_shift == AREQ_CODE);
    assign w_is_aund = (r_shift == AUND_CODE);
    assign w_is_data = r_pkt_done && !w_is_areq && !w_is_aund;
    assign w_consume = r_out_valid && out_ready;
    // A consumption on the completing edge frees the slot, so the new packet replaces it
    assign w_load    = w_is_data && (!r_out_valid || out_ready);
    assign w_drop    = w_is_data && r_out_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_bit_cnt        <= '0;
            r_gap_cnt        <= '0;
            r_shift          <= '0;
            r_pkt_done       <= 1'b0;
            r_frm_pend       <= 1'b0;
            r_out_data       <= '0;
            r_out_valid      <= 1'b0;
            r_audio_req      <= 1'b0;
            r_audio_underrun <= 1'b0;
            r_data_loss      <= 1'b0;
            r_framing_error  <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            r_frm_pend <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (sin) begin
                        r_state   <= ST_RECV;
                        r_bit_cnt <= '0;
                    end
                end
                ST_RECV: begin
                    r_shift <= {r_shift[PKT_BITS-2:0], sin};
                    if (r_bit_cnt == BIT_LAST) begin
                        r_state    <= ST_GAP;
                        r_bit_cnt  <= '0;
                        r_gap_cnt  <= '0;
                        r_pkt_done <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 7'd1;
                    end
                end
                ST_GAP: begin
                    // Any high sample restarts the idle count; a start bit here is not honoured
                    if (sin) begin
                        r_gap_cnt  <= '0;
                        r_frm_pend <= 1'b1;
                    end else if (r_gap_cnt == GAP_LAST) begin
                        r_state   <= ST_IDLE;
                        r_gap_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 7'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Pulse outputs: each driven fresh every cycle so they last exactly one cycle
            r_framing_error  <= r_frm_pend;
            r_audio_req      <= r_pkt_done && w_is_areq;
            r_audio_underrun <= r_pkt_done && w_is_aund;
            r_data_loss      <= w_drop;

            if (w_load) begin
                r_out_data  <= r_shift;
                r_out_valid <= 1'b1;
            end else if (w_consume) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data       = r_out_data;
    assign out_valid      = r_out_valid;
    assign audio_req      = r_audio_req;
    assign audio_underrun = r_audio_underrun;
    assign data_loss      = r_data_loss;
    assign framing_error  = r_framing_error;

endmodule

// File: tb/tb_packet_receiver.sv
// Directed bench for packet_receiver with default 40-bit packets and 3-bit gap.
// Line is driven on the falling edge; outputs are sampled 1 ns after the rising edge.
// Expected values are hand-computed constants per step.
module tb_packet_receiver;

    logic        clk;
    logic        rst_n;
    logic        sin;
    logic [39:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        audio_req;
    logic        audio_underrun;
    logic        data_loss;
    logic        framing_error;

    int checks   = 0;
    int failures = 0;

    // Pulse counters, accumulated after every sampled edge
    int n_areq = 0;
    int n_aund = 0;
    int n_loss = 0;
    int n_frm  = 0;

    packet_receiver dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sin            (sin),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .audio_req      (audio_req),
        .audio_underrun (audio_underrun),
        .data_loss      (data_loss),
        .framing_error  (framing_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_areq = 0;
        n_aund = 0;
        n_loss = 0;
        n_frm  = 0;
    endtask

    // Drive one bit at the falling edge, then sample just after the rising edge that takes it
    task automatic step(input logic b);
        @(negedge clk);
        sin = b;
        @(posedge clk);
        #1;
        if (audio_req)      n_areq++;
        if (audio_underrun) n_aund++;
        if (data_loss)      n_loss++;
        if (framing_error)  n_frm++;
    endtask

    // Start bit (edge N) plus 40 payload bits MSB first (edges N+1..N+40)
    task automatic send_pkt(input logic [39:0] p);
        step(1'b1);
        for (int i = 39; i >= 0; i--) step(p[i]);
    endtask

    initial begin
        logic [39:0] pa;
        logic [39:0] pb;
        logic [39:0] pc;
        logic [39:0] pd;
        logic [39:0] pe;
        logic [39:0] pf;
        logic [39:0] pg;

        rst_n     = 1'b0;
        sin       = 1'b0;
        out_ready = 1'b0;

        // Reset state, before any clock edge
        #2;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_pulses", 64'({audio_req, audio_underrun, data_loss, framing_error}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0);
        step(1'b0);

        // Single data packet with consumer ready
        clear_counts();
        out_ready = 1'b1;
        send_pkt(40'hD999999991);
        check("t1_valid_at_N40", 64'(out_valid), 64'd0);
        step(1'b0);                                         // N+41
        check("t1_valid_at_N41", 64'(out_valid), 64'd1);
        check("t1_data", 64'(out_data), 64'hD999999991);
        step(1'b0);                                         // N+42, consumed at N+41 edge? no: handshake at N+42
        check("t1_valid_cleared", 64'(out_valid), 64'd0);
        step(1'b0);
        check("t1_no_pulses", 64'(n_areq + n_aund + n_loss + n_frm), 64'd0);

        // Back-to-back control packets with minimal gap
        clear_counts();
        send_pkt(40'h0700000000);
        step(1'b0);                                         // N+41
        check("t2_areq_pulse", 64'(audio_req), 64'd1);
        step(1'b0);                                         // N+42
        check("t2_areq_one_cycle", 64'(audio_req), 64'd0);
        step(1'b0);                                         // N+43
        send_pkt(40'h0f00000000);                           // start at N+44
        step(1'b0);                                         // N+85
        check("t2_aund_pulse", 64'(audio_underrun), 64'd1);
        step(1'b0);
        step(1'b0);
        check("t2_valid_low", 64'(out_valid), 64'd0);
        check("t2_areq_count", 64'(n_areq), 64'd1);
        check("t2_aund_count", 64'(n_aund), 64'd1);

        // Two data packets while consumer stalls: second is dropped
        clear_counts();
        out_ready = 1'b0;
        pa = 40'h123456789A;
        pb = 40'hCAFEBABE00;
        send_pkt(pa);
        step(1'b0);
        check("t3_first_valid", 64'(out_valid), 64'd1);
        check("t3_first_data", 64'(out_data), 64'(pa));
        step(1'b0);
        step(1'b0);
        send_pkt(pb);
        step(1'b0);
        check("t3_loss_pulse", 64'(data_loss), 64'd1);
        check("t3_data_kept", 64'(out_data), 64'(pa));
        check("t3_valid_kept", 64'(out_valid), 64'd1);
        step(1'b0);
        step(1'b0);
        check("t3_loss_count", 64'(n_loss), 64'd1);

        // Consumption on the same edge a new data packet completes
        clear_counts();
        pc = 40'h5A5A5A5A5A;
        send_pkt(pc);
        out_ready = 1'b1;
        step(1'b0);
        check("t5_data_replaced", 64'(out_data), 64'(pc));
        check("t5_valid_stays", 64'(out_valid), 64'd1);
        check("t5_no_loss", 64'(data_loss), 64'd0);
        step(1'b0);
        check("t5_consumed", 64'(out_valid), 64'd0);
        step(1'b0);
        check("t5_loss_count", 64'(n_loss), 64'd0);

        // High sample in the gap, early start bit ignored
        clear_counts();
        pd = 40'h0123456789;
        pe = 40'h00000000FF;
        send_pkt(pd);
        step(1'b0);                                         // N+41
        step(1'b1);                                         // N+42 high in gap
        check("t4_frm_not_yet", 64'(framing_error), 64'd0);
        step(1'b0);                                         // N+43
        check("t4_frm_pulse", 64'(framing_error), 64'd1);
        step(1'b1);                                         // N+44 start bit, still in gap
        step(1'b0);                                         // N+45
        check("t4_frm_pulse2", 64'(framing_error), 64'd1);
        step(1'b0);
        step(1'b0);                                         // N+47 third low bit
        out_ready = 1'b0;
        send_pkt(pe);
        step(1'b0);
        check("t4_next_valid", 64'(out_valid), 64'd1);
        check("t4_next_data", 64'(out_data), 64'(pe));
        check("t4_frm_count", 64'(n_frm), 64'd2);
        step(1'b0);
        step(1'b0);

        // Reset in the middle of a packet
        clear_counts();
        pf = 40'hFFFFFFFFFF;
        pg = 40'hA5A5A5A5A5;
        step(1'b1);
        for (int i = 39; i >= 20; i--) step(pf[i]);
        #2;
        rst_n = 1'b0;
        sin   = 1'b0;
        #1;
        check("t6_async_valid", 64'(out_valid), 64'd0);
        check("t6_async_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0);
        step(1'b0);
        step(1'b0);
        send_pkt(pg);
        step(1'b0);
        check("t6_valid", 64'(out_valid), 64'd1);
        check("t6_data", 64'(out_data), 64'(pg));
        step(1'b0);
        step(1'b0);
        check("t6_no_frm", 64'(n_frm), 64'd0);
        check("t6_no_other_pulses", 64'(n_areq + n_aund + n_loss), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
